// File: rtl/mdu_multicycle_pkg.sv
// Shared MDU op codes, default latencies and op-class helpers.
// Imported by the interface, the arithmetic block and the MDU top.
package mdu_multicycle_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    function automatic logic is_mul(input mdu_op_e op);
        return op inside {MDU_MULT, MDU_MULTU, MDU_MADD,
                          MDU_MADDU, MDU_MSUB, MDU_MSUBU};
    endfunction

    function automatic logic is_div(input mdu_op_e op);
        return op inside {MDU_DIV, MDU_DIVU};
    endfunction

endpackage

// File: rtl/mdu_multicycle_if.sv
// E-stage to MDU bundle: issue side from the pipeline, HI/LO and busy back.
// Width follows the MDU operand width.
interface mdu_multicycle_if
    import mdu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic             cancel;
    mdu_op_e          mdu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, cancel, mdu_op, a, b,
        input  busy, hi, lo
    );

    modport slave (
        input  start, cancel, mdu_op, a, b,
        output busy, hi, lo
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: next {hi,lo} for any op, plus divide-by-zero flag.
// All results are modulo 2^(2*WIDTH).
module mdu_arith
    import mdu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] nhi,
    output logic [WIDTH-1:0] nlo,
    output logic             div0
);
    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0] sa, sb, ua, ub;
    logic [W2-1:0] ps, pu, acc, res;
    logic [WIDTH-1:0] ma, mb, qm, rm;
    logic [WIDTH-1:0] qs, rs, qu, ru;
    logic bz;

    assign sa  = {{WIDTH{a[WIDTH-1]}}, a};
    assign sb  = {{WIDTH{b[WIDTH-1]}}, b};
    assign ua  = {{WIDTH{1'b0}}, a};
    assign ub  = {{WIDTH{1'b0}}, b};
    assign ps  = sa * sb;
    assign pu  = ua * ub;
    assign acc = {hi, lo};
    assign bz  = (b == '0);

    // Signed divide on magnitudes; MIN/-1 wraps back to MIN with rem 0
    assign ma = a[WIDTH-1] ? -a : a;
    assign mb = b[WIDTH-1] ? -b : b;
    assign qm = bz ? '0 : ma / mb;
    assign rm = bz ? '0 : ma % mb;
    assign qs = (a[WIDTH-1] ^ b[WIDTH-1]) ? -qm : qm;
    assign rs = a[WIDTH-1] ? -rm : rm;
    assign qu = bz ? '0 : a / b;
    assign ru = bz ? '0 : a % b;

    always_comb begin
        res  = acc;
        div0 = 1'b0;
        case (op)
            MDU_MULT:  res = ps;
            MDU_MULTU: res = pu;
            MDU_MADD:  res = acc + ps;
            MDU_MADDU: res = acc + pu;
            MDU_MSUB:  res = acc - ps;
            MDU_MSUBU: res = acc - pu;
            MDU_DIV: begin
                res  = {rs, qs};
                div0 = bz;
            end
            MDU_DIVU: begin
                res  = {ru, qu};
                div0 = bz;
            end
            default:   res = acc;
        endcase
    end

    assign {nhi, nlo} = res;
endmodule

// File: rtl/mdu_multicycle.sv
// Multicycle MDU: stages the result at issue, commits to HI/LO after N busy cycles.
// cancel kills issue, MT writes and any in-flight op.
module mdu_multicycle
    import mdu_multicycle_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input logic              clk,
    input logic              reset,
    mdu_multicycle_if.slave  bus
);
    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_q, lo_q, shi, slo, nhi, nlo;
    logic             sdiv0, div0, busy, issue;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op   (bus.mdu_op),
        .a    (bus.a),
        .b    (bus.b),
        .hi   (hi_q),
        .lo   (lo_q),
        .nhi  (nhi),
        .nlo  (nlo),
        .div0 (div0)
    );

    assign busy  = (cnt != '0);
    assign issue = bus.start && !busy &&
                   (is_mul(bus.mdu_op) || is_div(bus.mdu_op));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            shi   <= '0;
            slo   <= '0;
            sdiv0 <= 1'b0;
        end else if (bus.cancel) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
            // Divide by zero still takes the full latency, but never commits
            if (cnt == CW'(1) && !sdiv0) begin
                hi_q <= shi;
                lo_q <= slo;
            end
        end else if (issue) begin
            shi   <= nhi;
            slo   <= nlo;
            sdiv0 <= div0;
            cnt   <= is_div(bus.mdu_op) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
        end else if (bus.mdu_op == MDU_MTHI) begin
            hi_q <= bus.a;
        end else if (bus.mdu_op == MDU_MTLO) begin
            lo_q <= bus.a;
        end
    end

    assign bus.busy = busy;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_multicycle.sv
// Scoreboard bench for mdu_multicycle: 32-bit default instance and a
// 16-bit single-cycle-multiply instance.
module tb_mdu_multicycle
    import mdu_multicycle_pkg::*;
;
    typedef struct {
        logic [63:0] hl;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    exp_t q32[$];
    exp_t q16[$];
    int   run32 = 0;
    int   run16 = 0;

    always #5 clk = ~clk;

    mdu_multicycle_if #(.WIDTH(32)) m32 ();
    mdu_multicycle_if #(.WIDTH(16)) m16 ();

    mdu_multicycle #(.WIDTH(32)) u32 (
        .clk   (clk),
        .reset (reset),
        .bus   (m32)
    );

    mdu_multicycle #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)) u16 (
        .clk   (clk),
        .reset (reset),
        .bus   (m16)
    );

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Monitors: count busy cycles, compare when busy falls
    always @(negedge clk) begin
        if (m32.busy === 1'b1) begin
            run32++;
        end else if (run32 > 0) begin
            exp_t e;
            if (q32.size() == 0) begin
                chk("sb32_unexpected_end", 64'(run32), 64'd0);
            end else begin
                e = q32.pop_front();
                chk("busy_len32", 64'(run32), 64'(e.cyc));
                chk("hilo32", {m32.hi, m32.lo}, e.hl);
            end
            run32 = 0;
        end
    end

    always @(negedge clk) begin
        if (m16.busy === 1'b1) begin
            run16++;
        end else if (run16 > 0) begin
            exp_t e;
            if (q16.size() == 0) begin
                chk("sb16_unexpected_end", 64'(run16), 64'd0);
            end else begin
                e = q16.pop_front();
                chk("busy_len16", 64'(run16), 64'(e.cyc));
                chk("hilo16", {32'd0, m16.hi, m16.lo}, e.hl);
            end
            run16 = 0;
        end
    end

    task automatic push32(input logic [63:0] hl, input int cyc);
        exp_t e;
        e.hl  = hl;
        e.cyc = cyc;
        q32.push_back(e);
    endtask

    task automatic push16(input logic [63:0] hl, input int cyc);
        exp_t e;
        e.hl  = hl;
        e.cyc = cyc;
        q16.push_back(e);
    endtask

    task automatic issue32(input mdu_op_e op, input logic [31:0] a,
                           input logic [31:0] b);
        m32.start  = 1'b1;
        m32.mdu_op = op;
        m32.a      = a;
        m32.b      = b;
        @(posedge clk); #1;
        m32.start  = 1'b0;
        m32.mdu_op = MDU_NONE;
    endtask

    task automatic issue16(input mdu_op_e op, input logic [15:0] a,
                           input logic [15:0] b);
        m16.start  = 1'b1;
        m16.mdu_op = op;
        m16.a      = a;
        m16.b      = b;
        @(posedge clk); #1;
        m16.start  = 1'b0;
        m16.mdu_op = MDU_NONE;
    endtask

    task automatic mt32(input mdu_op_e op, input logic [31:0] a);
        m32.mdu_op = op;
        m32.a      = a;
        @(posedge clk); #1;
        m32.mdu_op = MDU_NONE;
    endtask

    task automatic idle32();
        int n = 0;
        while (m32.busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (m32.busy !== 1'b0) chk("timeout32", 64'(m32.busy), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle16();
        int n = 0;
        while (m16.busy !== 1'b0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (m16.busy !== 1'b0) chk("timeout16", 64'(m16.busy), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        m32.start = 1'b0; m32.cancel = 1'b0; m32.mdu_op = MDU_NONE;
        m32.a = '0; m32.b = '0;
        m16.start = 1'b0; m16.cancel = 1'b0; m16.mdu_op = MDU_NONE;
        m16.a = '0; m16.b = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_hi", 64'(m32.hi), 64'd0);
        chk("rst_lo", 64'(m32.lo), 64'd0);
        chk("rst_busy", 64'(m32.busy), 64'd0);

        // Reset in busy cycle 2 aborts the op
        issue32(MDU_MULT, 32'd3, 32'hFFFF_FFFC);
        push32(64'h0, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_mid_busy", 64'(m32.busy), 64'd0);
        @(posedge clk); #1;

        issue32(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
        push32(64'hFFFF_FFFF_FFFF_FFFE, 5);
        idle32();

        issue32(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
        push32(64'hFFFF_FFFF_FFFF_FFFD, 10);
        idle32();

        issue32(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
        push32(64'h0000_0001_FFFF_FFFD, 10);
        idle32();

        issue32(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        push32(64'h0000_0000_8000_0000, 10);
        idle32();

        issue32(MDU_DIVU, 32'd7, 32'd0);
        push32(64'h0000_0000_8000_0000, 10);
        idle32();

        mt32(MDU_MTHI, 32'd0);
        mt32(MDU_MTLO, 32'hFFFF_FFFF);
        chk("mthi", 64'(m32.hi), 64'd0);
        chk("mtlo", 64'(m32.lo), 64'hFFFF_FFFF);

        issue32(MDU_MADDU, 32'd1, 32'd1);
        push32(64'h0000_0001_0000_0000, 5);
        idle32();

        issue32(MDU_MSUB, 32'd1, 32'd1);
        push32(64'h0000_0000_FFFF_FFFF, 5);
        idle32();

        // Cancel in busy cycle 3
        issue32(MDU_MULT, 32'd5, 32'd5);
        push32(64'h0000_0000_FFFF_FFFF, 3);
        repeat (2) begin
            @(posedge clk); #1;
        end
        m32.cancel = 1'b1;
        @(posedge clk); #1;
        m32.cancel = 1'b0;
        chk("cancel_busy", 64'(m32.busy), 64'd0);
        @(posedge clk); #1;

        // start + cancel together: no issue
        m32.cancel = 1'b1;
        issue32(MDU_MULT, 32'd2, 32'd2);
        m32.cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("start_cancel_busy", 64'(m32.busy), 64'd0);
            @(posedge clk); #1;
        end

        m32.cancel = 1'b1;
        mt32(MDU_MTHI, 32'hDEAD_BEEF);
        m32.cancel = 1'b0;
        chk("mthi_cancel", 64'(m32.hi), 64'd0);

        // MTLO and start while busy are ignored
        issue32(MDU_MULTU, 32'd2, 32'd3);
        push32(64'h0000_0000_0000_0006, 5);
        mt32(MDU_MTLO, 32'h0000_1234);
        issue32(MDU_MULT, 32'd7, 32'd7);
        idle32();
        chk("lo_after_ignored", 64'(m32.lo), 64'd6);

        issue32(MDU_MADD, 32'hFFFF_FFFE, 32'd3);
        push32(64'h0, 5);
        idle32();

        issue32(MDU_MSUBU, 32'hFFFF_FFFF, 32'd2);
        push32(64'hFFFF_FFFE_0000_0002, 5);
        idle32();

        issue16(MDU_MULT, 16'hFFFF, 16'd2);
        push16(64'h0000_0000_FFFF_FFFE, 1);
        idle16();

        issue16(MDU_DIVU, 16'd100, 16'd7);
        push16(64'h0000_0000_0002_000E, 10);
        idle16();

        repeat (3) @(posedge clk);
        #1;
        chk("sb32_drained", 64'(q32.size()), 64'd0);
        chk("sb16_drained", 64'(q16.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
